ysyx_22041071_div_ctrl: RTL and testbench

Execute-stage controller for the RV64M divide/remainder instructions (DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW). It sits directly upstream of the iterative 64-bit divider: it accepts an operation from EXE and stalls the pipeline while busy. It resolves RISC-V special cases (divide-by-zero, signed overflow) itself without launching the divider. Otherwise it holds the divider handshake stable for the whole operation, selects quotient or remainder, applies W-variant sign extension, and returns a registered result.

---
 rtl/ysyx_22041071_div_ctrl_pkg.sv | 28 ++
 rtl/ysyx_22041071_div_ctrl.sv | 129 ++++++++++++
 tb/tb_ysyx_22041071_div_ctrl.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_22041071_div_ctrl_pkg.sv
// Shared encodings and constants for the RV64M divide/remainder controller.
package ysyx_22041071_div_ctrl_pkg;

    localparam int unsigned DATA_BUS = 64;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BUSY  = 2'd1,
        S_DRAIN = 2'd2,
        S_RESP  = 2'd3
    } div_state_e;

    localparam logic [DATA_BUS-1:0] INT64_MIN = 64'h8000_0000_0000_0000;
    localparam logic [31:0]         INT32_MIN = 32'h8000_0000;
    localparam logic [DATA_BUS-1:0] ALL_ONES  = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [DATA_BUS-1:0] sext32(input logic [DATA_BUS-1:0] x);
        return {{32{x[31]}}, x[31:0]};
    endfunction

endpackage

// File: rtl/ysyx_22041071_div_ctrl.sv
// EXE-stage controller for DIV/REM ops: resolves RISC-V special cases locally,
// otherwise runs the external iterative divider and formats its result.
module ysyx_22041071_div_ctrl
    import ysyx_22041071_div_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                i_flush,
    input  logic                i_op_valid,
    input  logic [1:0]          i_op,
    input  logic                i_op_w,
    input  logic [DATA_BUS-1:0] i_src1,
    input  logic [DATA_BUS-1:0] i_src2,
    output logic                o_stall,
    output logic                o_res_valid,
    output logic [DATA_BUS-1:0] o_result,
    output logic                o_div_valid,
    output logic                o_div_signed,
    output logic                o_divw,
    output logic [DATA_BUS-1:0] o_dividend,
    output logic [DATA_BUS-1:0] o_divisor,
    input  logic                i_div_ready,
    input  logic                i_out_valid,
    input  logic [DATA_BUS-1:0] i_quot,
    input  logic [DATA_BUS-1:0] i_rema
);

    div_state_e          r_state;
    logic                r_sel_rem;
    logic                r_op_w;
    logic [DATA_BUS-1:0] r_result;
    logic                r_div_valid;
    logic                r_div_signed;
    logic                r_divw;
    logic [DATA_BUS-1:0] r_dividend;
    logic [DATA_BUS-1:0] r_divisor;

    logic                w_accept;
    logic                w_div_zero;
    logic                w_overflow;
    logic                w_special;
    logic [DATA_BUS-1:0] w_special_raw;
    logic [DATA_BUS-1:0] w_special_res;
    logic [DATA_BUS-1:0] w_div_raw;
    logic [DATA_BUS-1:0] w_div_res;

    // Special-case classification works on the live operands during acceptance.
    assign w_accept   = (r_state == S_IDLE) && i_op_valid && !i_flush;
    assign w_div_zero = i_op_w ? (i_src2[31:0] == 32'h0) : (i_src2 == '0);
    assign w_overflow = !i_op[0] &&
                        (i_op_w ? ((i_src1[31:0] == INT32_MIN) && (i_src2[31:0] == 32'hFFFF_FFFF))
                                : ((i_src1 == INT64_MIN) && (i_src2 == ALL_ONES)));
    assign w_special  = w_div_zero || w_overflow;

    assign w_special_raw = w_div_zero ? (i_op[1] ? i_src1 : ALL_ONES)
                                      : (i_op[1] ? '0 : i_src1);
    assign w_special_res = i_op_w ? sext32(w_special_raw) : w_special_raw;

    assign w_div_raw = r_sel_rem ? i_rema : i_quot;
    assign w_div_res = r_op_w ? sext32(w_div_raw) : w_div_raw;

    // Stall and strobe must react in the same cycle as op_valid/flush.
    assign o_stall     = w_accept || (r_state == S_BUSY) || (r_state == S_DRAIN);
    assign o_res_valid = (r_state == S_RESP) && !i_flush;

    assign o_result     = r_result;
    assign o_div_valid  = r_div_valid;
    assign o_div_signed = r_div_signed;
    assign o_divw       = r_divw;
    assign o_dividend   = r_dividend;
    assign o_divisor    = r_divisor;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sel_rem    <= 1'b0;
            r_op_w       <= 1'b0;
            r_result     <= '0;
            r_div_valid  <= 1'b0;
            r_div_signed <= 1'b0;
            r_divw       <= 1'b0;
            r_dividend   <= '0;
            r_divisor    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_special || i_div_ready)) begin
                        r_sel_rem    <= i_op[1];
                        r_op_w       <= i_op_w;
                        r_div_signed <= !i_op[0];
                        r_divw       <= i_op_w;
                        r_dividend   <= i_src1;
                        r_divisor    <= i_src2;
                        if (w_special) begin
                            r_result <= w_special_res;
                            r_state  <= S_RESP;
                        end else begin
                            r_div_valid <= 1'b1;
                            r_state     <= S_BUSY;
                        end
                    end
                end
                S_BUSY: begin
                    // A flush coinciding with the strobe leaves nothing to drain.
                    if (i_flush) begin
                        r_div_valid <= 1'b0;
                        r_state     <= i_out_valid ? S_IDLE : S_DRAIN;
                    end else if (i_out_valid) begin
                        r_div_valid <= 1'b0;
                        r_result    <= w_div_res;
                        r_state     <= S_RESP;
                    end
                end
                S_DRAIN: begin
                    if (i_out_valid) begin
                        r_state <= S_IDLE;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_div_ctrl.sv
// Directed bench for ysyx_22041071_div_ctrl with a fixed-latency divider model.
module tb_ysyx_22041071_div_ctrl;
    import ysyx_22041071_div_ctrl_pkg::*;

    localparam int unsigned LAT = 20;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_flush, i_op_valid, i_op_w;
    logic [1:0]  i_op;
    logic [63:0] i_src1, i_src2;
    logic        o_stall, o_res_valid, o_div_valid, o_div_signed, o_divw;
    logic [63:0] o_result, o_dividend, o_divisor;
    logic        i_div_ready, i_out_valid;
    logic [63:0] i_quot, i_rema;

    int errors = 0;
    int checks = 0;

    ysyx_22041071_div_ctrl dut (
        .clk(clk), .reset(reset), .i_flush(i_flush), .i_op_valid(i_op_valid),
        .i_op(i_op), .i_op_w(i_op_w), .i_src1(i_src1), .i_src2(i_src2),
        .o_stall(o_stall), .o_res_valid(o_res_valid), .o_result(o_result),
        .o_div_valid(o_div_valid), .o_div_signed(o_div_signed), .o_divw(o_divw),
        .o_dividend(o_dividend), .o_divisor(o_divisor),
        .i_div_ready(i_div_ready), .i_out_valid(i_out_valid),
        .i_quot(i_quot), .i_rema(i_rema)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [63:0] q;
        logic [63:0] r;
    } qr_t;

    function automatic qr_t div_model(input logic [63:0] a, input logic [63:0] b,
                                      input logic sgn, input logic w);
        qr_t o;
        logic [31:0] a32, b32, q32, r32;
        a32 = a[31:0];
        b32 = b[31:0];
        if (w) begin
            if (b32 == 32'h0) begin q32 = '1; r32 = a32; end
            else if (sgn && a32 == 32'h8000_0000 && b32 == 32'hFFFF_FFFF) begin q32 = a32; r32 = '0; end
            else if (sgn) begin
                q32 = 32'($signed(a32) / $signed(b32));
                r32 = 32'($signed(a32) % $signed(b32));
            end else begin q32 = a32 / b32; r32 = a32 % b32; end
            o.q = {32'h0, q32};
            o.r = {32'h0, r32};
        end else begin
            if (b == 64'h0) begin o.q = '1; o.r = a; end
            else if (sgn && a == INT64_MIN && b == ALL_ONES) begin o.q = a; o.r = '0; end
            else if (sgn) begin
                o.q = 64'($signed(a) / $signed(b));
                o.r = 64'($signed(a) % $signed(b));
            end else begin o.q = a / b; o.r = a % b; end
        end
        return o;
    endfunction

    // Divider model: samples a request when idle, strobes LAT cycles later.
    logic        m_busy;
    int          m_cnt;
    qr_t         m_res;
    logic [63:0] m_dvd, m_dvs;
    logic        m_sgn, m_w;
    int          launches = 0;
    int          hold_err = 0;
    int          viol = 0;
    logic        prev_ov = 1'b0;

    assign i_div_ready = !m_busy && !i_out_valid;

    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0; m_cnt <= 0; i_out_valid <= 1'b0; i_quot <= '0; i_rema <= '0;
        end else begin
            i_out_valid <= 1'b0;
            if ((m_busy || i_out_valid) && o_div_valid &&
                (o_dividend != m_dvd || o_divisor != m_dvs || o_div_signed != m_sgn || o_divw != m_w))
                hold_err <= hold_err + 1;
            if (m_busy) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_busy <= 1'b0; i_out_valid <= 1'b1; i_quot <= m_res.q; i_rema <= m_res.r;
                end
            end else if (!i_out_valid && o_div_valid) begin
                m_busy <= 1'b1; m_cnt <= LAT; launches <= launches + 1;
                m_dvd <= o_dividend; m_dvs <= o_divisor; m_sgn <= o_div_signed; m_w <= o_divw;
                m_res <= div_model(o_dividend, o_divisor, o_div_signed, o_divw);
            end
        end
    end

    always @(negedge clk) begin
        prev_ov <= i_out_valid;
        if (prev_ov && o_div_valid) viol <= viol + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0]  op;
        logic        w;
        logic [63:0] s1;
        logic [63:0] s2;
        bit          special;
        logic [63:0] exp;
    } vec_t;

    vec_t vecs[17];

    task automatic run_op(input int idx, input vec_t v);
        int cyc, ov_at, l0;
        bit done, stall_ok, req_seen, req_ok;
        logic [63:0] res;
        string nm;
        nm = $sformatf("vec%0d", idx);
        l0 = launches;
        @(negedge clk);
        i_op_valid = 1'b1; i_op = v.op; i_op_w = v.w; i_src1 = v.s1; i_src2 = v.s2;
        #1 stall_ok = o_stall;
        cyc = 0; ov_at = -1; done = 0; req_seen = 0; req_ok = 0; res = '0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_res_valid) begin
                done = 1; res = o_result;
                if (o_stall) stall_ok = 0;
            end else begin
                if (!o_stall) stall_ok = 0;
                if (i_out_valid) ov_at = cyc;
                if (o_div_valid && !req_seen) begin
                    req_seen = 1;
                    req_ok = (o_dividend == v.s1) && (o_divisor == v.s2) &&
                             (o_div_signed == !v.op[0]) && (o_divw == v.w);
                end
            end
        end
        i_op_valid = 1'b0;
        check({nm, "_done"}, 64'(done), 64'd1);
        check({nm, "_result"}, res, v.exp);
        check({nm, "_stall"}, 64'(stall_ok), 64'd1);
        if (v.special) begin
            check({nm, "_latency"}, 64'(cyc), 64'd1);
            check({nm, "_no_launch"}, 64'(launches - l0), 64'd0);
        end else begin
            check({nm, "_resp_after_ov"}, 64'(cyc), 64'(ov_at + 1));
            check({nm, "_launch"}, 64'(launches - l0), 64'd1);
            check({nm, "_div_req"}, 64'(req_ok), 64'd1);
        end
    endtask

    task automatic wait_res(input string nm, output logic [63:0] res, output int nres);
        int cyc;
        bit done;
        cyc = 0; done = 0; res = '0; nres = 0;
        while (!done && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (o_res_valid) begin done = 1; res = o_result; nres++; end
        end
        check({nm, "_done"}, 64'(done), 64'd1);
    endtask

    initial begin
        logic [63:0] res;
        int nres, l0, cyc;

        vecs[0]  = '{2'b00, 1'b0, 64'd100, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 64'hFFFF_FFFF_FFFF_FFF2};
        vecs[1]  = '{2'b11, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'h10, 1'b0, 64'h5};
        vecs[2]  = '{2'b01, 1'b1, 64'hFFFF_FFFF_8000_0005, 64'h10, 1'b0, 64'h0800_0000};
        vecs[3]  = '{2'b00, 1'b1, 64'h8000_0000, 64'd2, 1'b0, 64'hFFFF_FFFF_C000_0000};
        vecs[4]  = '{2'b00, 1'b0, 64'd42, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[5]  = '{2'b10, 1'b0, 64'd42, 64'd0, 1'b1, 64'd42};
        vecs[6]  = '{2'b10, 1'b1, 64'h1_8000_0000, 64'd0, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[7]  = '{2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h8000_0000_0000_0000};
        vecs[8]  = '{2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 64'h0};
        vecs[9]  = '{2'b00, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_8000_0000};
        vecs[10] = '{2'b01, 1'b0, 64'd1000, 64'd7, 1'b0, 64'd142};
        vecs[11] = '{2'b11, 1'b0, 64'd1000, 64'd7, 1'b0, 64'd6};
        vecs[12] = '{2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 1'b0, 64'hFFFF_FFFF_FFFF_FFFE};
        vecs[13] = '{2'b01, 1'b1, 64'h1234_5678, 64'hFFFF_FFFF_0000_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[14] = '{2'b01, 1'b0, 64'h5_0000_0000, 64'h1_0000_0000, 1'b0, 64'd5};
        vecs[15] = '{2'b01, 1'b1, 64'hFFFF_FFFF, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF};
        vecs[16] = '{2'b01, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 64'h0};

        reset = 1'b1; i_flush = 1'b0; i_op_valid = 1'b0; i_op = 2'b00; i_op_w = 1'b0;
        i_src1 = '0; i_src2 = '0;
        repeat (2) @(negedge clk);
        check("rst_ctrl", 64'({o_stall, o_res_valid, o_div_valid, o_div_signed, o_divw}), 64'd0);
        check("rst_result", o_result, 64'd0);
        check("rst_operands", o_dividend | o_divisor, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 17; i++) run_op(i, vecs[i]);

        // Flush while idle must block acceptance.
        @(negedge clk);
        i_op_valid = 1'b1; i_flush = 1'b1; i_op = 2'b00; i_op_w = 1'b0; i_src1 = 64'd42; i_src2 = 64'd0;
        #1 check("idle_flush_stall", 64'(o_stall), 64'd0);
        @(negedge clk);
        i_flush = 1'b0; i_op_valid = 1'b0;
        check("idle_flush_block", 64'(o_res_valid), 64'd0);

        // Flush in RESP suppresses the strobe.
        @(negedge clk);
        i_op_valid = 1'b1;
        @(negedge clk);
        i_flush = 1'b1; i_op_valid = 1'b0;
        #1 check("resp_flush", 64'(o_res_valid), 64'd0);
        @(negedge clk);
        i_flush = 1'b0;
        check("resp_flush_after", 64'(o_res_valid), 64'd0);

        // Flush mid-divide, then a new op presented during drain.
        l0 = launches;
        @(negedge clk);
        i_op_valid = 1'b1; i_op = 2'b01; i_op_w = 1'b0; i_src1 = 64'd1000; i_src2 = 64'd7;
        cyc = 0;
        while (!o_div_valid && cyc < 50) begin @(negedge clk); cyc++; end
        repeat (10) @(negedge clk);
        check("flush_pre_busy", 64'(o_div_valid), 64'd1);
        i_flush = 1'b1; i_op_valid = 1'b0;
        @(negedge clk);
        i_flush = 1'b0;
        check("flush_drain_dv", 64'(o_div_valid), 64'd0);
        check("flush_drain_stall", 64'(o_stall), 64'd1);
        i_op_valid = 1'b1; i_src2 = 64'd3;
        wait_res("drain_new", res, nres);
        i_op_valid = 1'b0;
        check("drain_new_result", res, 64'd333);
        check("drain_launches", 64'(launches - l0), 64'd2);

        // Back-to-back DIVU ops.
        @(negedge clk);
        i_op_valid = 1'b1; i_op = 2'b01; i_op_w = 1'b0; i_src1 = 64'd1000; i_src2 = 64'd7;
        cyc = 0;
        while (!i_out_valid && cyc < 100) begin @(negedge clk); cyc++; end
        @(negedge clk);
        check("b2b_gap_dv", 64'(o_div_valid), 64'd0);
        check("b2b_first_valid", 64'(o_res_valid), 64'd1);
        check("b2b_first_result", o_result, 64'd142);
        i_src2 = 64'd3;
        @(negedge clk);
        check("b2b_accept_stall", 64'(o_stall), 64'd1);
        @(negedge clk);
        check("b2b_launch", 64'(o_div_valid), 64'd1);
        wait_res("b2b_second", res, nres);
        i_op_valid = 1'b0;
        check("b2b_second_result", res, 64'd333);

        // Reset in the middle of a divide.
        @(negedge clk);
        i_op_valid = 1'b1; i_op = 2'b00; i_src1 = 64'd100; i_src2 = 64'hFFFF_FFFF_FFFF_FFF9;
        repeat (5) @(negedge clk);
        check("midrst_busy", 64'(o_div_valid), 64'd1);
        reset = 1'b1; i_op_valid = 1'b0;
        @(negedge clk);
        check("midrst_ctrl", 64'({o_stall, o_res_valid, o_div_valid, o_div_signed, o_divw}), 64'd0);
        check("midrst_result", o_result, 64'd0);
        check("midrst_operands", o_dividend | o_divisor, 64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        check("operand_hold", 64'(hold_err), 64'd0);
        check("no_relaunch", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
